// File: rtl/fetch_buffer.sv
// Instruction fetch front-end for ROM port A: sequential one-word requests,
// a small prefetch FIFO of {word, pc}, and redirect flushing on jump_i.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module fetch_buffer #(
  parameter int unsigned            ADDR_WIDTH = `RISCV_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = '0,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         mem_valid_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic                         mem_ready_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] mem_rdata_i,
  input  logic                         jump_i,
  input  logic [ADDR_WIDTH-1:0]        jump_addr_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]        pc_o
);

  localparam int unsigned WORD_WIDTH = `RISCV_WORD_WIDTH;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  in_flight_q, in_flight_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [WORD_WIDTH-1:0] fifo_word_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_word_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy counts the word already owed by the ROM so the FIFO can never overflow.
  always_comb begin
    occupancy     = OCC_W'(count_q) + OCC_W'(in_flight_q) - OCC_W'(pop);
    instr_valid_o = rst_n & ~jump_i & (count_q != '0);
    pop           = instr_valid_o & instr_ready_i;
    push          = mem_ready_i & in_flight_q & ~drop_q & ~jump_i;
    mem_valid_o   = rst_n & ~jump_i & (occupancy < DEPTH_OCC);
    mem_addr_o    = fetch_pc_q;
    instr_o       = fifo_word_q[rd_ptr_q];
    pc_o          = fifo_pc_q[rd_ptr_q];
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = mem_valid_o;
    drop_d      = drop_q & in_flight_q & ~mem_ready_i;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_word_d = fifo_word_q;
    fifo_pc_d   = fifo_pc_q;

    if (mem_valid_o) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      req_pc_d   = fetch_pc_q;
    end

    if (jump_i) begin
      fetch_pc_d = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
      // A response still owed after the redirect must not land in the new stream.
      drop_d     = in_flight_q & ~mem_ready_i;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fifo_word_d[wr_ptr_q] = mem_rdata_i;
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q  <= BOOT_ADDR;
      in_flight_q <= 1'b0;
      drop_q      <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q    <= req_pc_d;
    fifo_word_q <= fifo_word_d;
    fifo_pc_q   <= fifo_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count_q == DEPTH_CNT)))
        else $error("fetch_buffer: push into full prefetch FIFO");
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic, compared every
// cycle against a queue-based model, and a second narrow instance for PC wrap.
module tb_fetch_buffer;

  localparam int DEPTH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  logic        w_mem_valid;
  logic [7:0]  w_mem_addr;
  logic        w_mem_ready;
  logic [31:0] w_mem_rdata;
  logic        w_jump;
  logic [7:0]  w_jump_addr;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [7:0]  w_pc;

  fetch_buffer #(.ADDR_WIDTH(32), .BOOT_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  fetch_buffer #(.ADDR_WIDTH(8), .BOOT_ADDR(8'hF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_o(w_mem_valid), .mem_addr_o(w_mem_addr),
    .mem_ready_i(w_mem_ready), .mem_rdata_i(w_mem_rdata),
    .jump_i(w_jump), .jump_addr_i(w_jump_addr),
    .instr_valid_o(w_instr_valid), .instr_ready_i(w_instr_ready),
    .instr_o(w_instr), .pc_o(w_pc)
  );

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t issues[$];
  rec_t dels[$];
  rec_t w_issues[$];
  rec_t w_dels[$];

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_fetch_pc = 32'h0;
  logic [31:0] m_if_pc = 32'h0;
  bit          m_if = 1'b0;

  // ROM responders
  bit          rom_pend = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  bit          w_pend = 1'b0;
  logic [7:0]  w_addr = 8'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic do_cycle(input bit rst, input bit jmp, input logic [31:0] ja, input bit rdy);
    bit   exp_iv, exp_pop, exp_mv;
    rec_t r;
    ent_t e;
    rst_n         = rst;
    jump_i        = jmp;
    jump_addr_i   = ja;
    instr_ready_i = rdy;
    if (rom_pend) begin
      mem_ready_i = 1'b1;
      mem_rdata_i = rom(rom_addr);
    end else begin
      // stray strobes with nothing outstanding must be ignored
      mem_ready_i = ($urandom_range(7) == 0);
      mem_rdata_i = $urandom;
    end
    w_mem_ready = w_pend;
    w_mem_rdata = 32'h2000 + 32'(w_addr);

    @(negedge clk);
    exp_iv  = rst && !jmp && (mq.size() != 0);
    exp_pop = exp_iv && rdy;
    exp_mv  = rst && !jmp && ((int'(mq.size()) + int'(m_if) - int'(exp_pop)) < DEPTH);
    check("mem_valid", 32'(mem_valid_o), 32'(exp_mv));
    if (exp_mv) check("mem_addr", mem_addr_o, m_fetch_pc);
    check("instr_valid", 32'(instr_valid_o), 32'(exp_iv));
    if (exp_iv) begin
      check("instr", instr_o, mq[0].w);
      check("pc", pc_o, mq[0].pc);
    end

    if (mem_valid_o) begin
      r.cyc = cyc; r.a = mem_addr_o; r.b = 32'h0;
      issues.push_back(r);
    end
    if (instr_valid_o && rdy) begin
      r.cyc = cyc; r.a = pc_o; r.b = instr_o;
      dels.push_back(r);
    end
    if (w_mem_valid) begin
      r.cyc = cyc; r.a = 32'(w_mem_addr); r.b = 32'h0;
      w_issues.push_back(r);
    end
    if (w_instr_valid) begin
      r.cyc = cyc; r.a = 32'(w_pc); r.b = w_instr;
      w_dels.push_back(r);
    end
    rom_pend = mem_valid_o;
    rom_addr = mem_addr_o;
    w_pend   = w_mem_valid;
    w_addr   = w_mem_addr;

    if (!rst) begin
      mq.delete();
      m_if       = 1'b0;
      m_fetch_pc = 32'h0;
    end else if (jmp) begin
      mq.delete();
      m_if       = 1'b0;
      m_fetch_pc = ja & ~32'h3;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (m_if && mem_ready_i) begin
        e.w = mem_rdata_i; e.pc = m_if_pc;
        mq.push_back(e);
      end
      if (exp_mv) begin
        m_if_pc    = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_if = exp_mv;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int a0, ia, da, s0, j, n;
    rst_n = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0; instr_ready_i = 1'b0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    w_mem_ready = 1'b0; w_mem_rdata = 32'h0; w_jump = 1'b0; w_jump_addr = 8'h0;
    w_instr_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) do_cycle(0, 0, 32'h0, 1);

    // boot stream
    a0 = cyc; ia = issues.size(); da = dels.size();
    repeat (8) do_cycle(1, 0, 32'h0, 1);
    check("boot_issue_count", 32'(issues.size() - ia), 32'd8);
    check("boot_del_count", 32'(dels.size() - da), 32'd6);
    check("boot_issue_addr", issues[ia].a, 32'h0);
    check("boot_issue_cyc", 32'(issues[ia].cyc), 32'(a0));
    check("seq_issue_1", issues[ia+1].a, 32'h4);
    check("seq_issue_2", issues[ia+2].a, 32'h8);
    check("first_valid_cyc", 32'(dels[da].cyc), 32'(a0 + 2));
    check("first_instr", dels[da].b, 32'h1000);
    check("first_pc", dels[da].a, 32'h0);
    check("second_valid_cyc", 32'(dels[da+1].cyc), 32'(a0 + 3));
    check("second_instr", dels[da+1].b, 32'h1001);

    check("wrap_issue_0", w_issues[0].a, 32'hF8);
    check("wrap_issue_1", w_issues[1].a, 32'hFC);
    check("wrap_issue_2", w_issues[2].a, 32'h00);
    check("wrap_issue_3", w_issues[3].a, 32'h04);
    check("wrap_first_pc", w_dels[0].a, 32'hF8);
    check("wrap_first_instr", w_dels[0].b, 32'h20F8);
    check("wrap_third_pc", w_dels[2].a, 32'h00);

    // back-pressure: FIFO fills, fetch stalls, then drains without gaps
    s0 = cyc; ia = issues.size();
    repeat (6) do_cycle(1, 0, 32'h0, 0);
    n = 0;
    foreach (issues[k]) if (issues[k].cyc > s0) n++;
    check("stall_issues", 32'(n), 32'd0);
    check("stall_first_issue", 32'(issues.size() - ia), 32'd1);
    n = dels.size();
    repeat (10) do_cycle(1, 0, 32'h0, 1);
    check("release_cyc", 32'(dels[n].cyc), 32'(s0 + 6));
    for (int k = da; k < dels.size(); k++) begin
      check("stream_pc", dels[k].a, 32'(4 * (k - da)));
      check("stream_instr", dels[k].b, 32'h1000 + 32'(k - da));
    end

    // redirect with two entries queued and one request in flight
    j = cyc; ia = issues.size(); da = dels.size();
    do_cycle(1, 1, 32'h40, 1);
    repeat (6) do_cycle(1, 0, 32'h0, 1);
    check("jump_issue_cyc", 32'(issues[ia].cyc), 32'(j + 1));
    check("jump_issue_addr", issues[ia].a, 32'h40);
    check("jump_del_cyc", 32'(dels[da].cyc), 32'(j + 3));
    check("jump_del_pc", dels[da].a, 32'h40);
    check("jump_del_instr", dels[da].b, 32'h1010);
    check("jump_del_next_pc", dels[da+1].a, 32'h44);

    // unaligned redirect target
    j = cyc; ia = issues.size(); da = dels.size();
    do_cycle(1, 1, 32'h47, 1);
    repeat (5) do_cycle(1, 0, 32'h0, 1);
    check("ujump_issue_addr", issues[ia].a, 32'h44);
    check("ujump_del_pc", dels[da].a, 32'h44);
    check("ujump_del_instr", dels[da].b, 32'h1011);
    check("ujump_del_cyc", 32'(dels[da].cyc), 32'(j + 3));

    // one-cycle reset mid-stream with a request outstanding
    j = cyc; da = dels.size();
    do_cycle(0, 0, 32'h0, 1);
    repeat (6) do_cycle(1, 0, 32'h0, 1);
    check("rst_del_cyc", 32'(dels[da].cyc), 32'(j + 3));
    check("rst_del_pc", dels[da].a, 32'h0);
    check("rst_del_instr", dels[da].b, 32'h1000);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      do_cycle(($urandom_range(199) != 0), ($urandom_range(15) == 0), $urandom,
               ($urandom_range(9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
